// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: one outstanding fetch, fixed access
// latency, valid/ready response channel and a side load port for the text
// segment.
module imem_fetch_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   input  logic [31:0]                    req_addr,
   output logic                           req_ready,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_instr,
   output logic [31:0]                    rsp_addr,
   output logic                           rsp_err,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
   input  logic [31:0]                    ld_data
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
   localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic                err_q, err_d;
   logic                req_ready_q, rsp_valid_q;

   logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

   logic [DATA_W-1:0]   word_off_c;
   logic                misalign_c;
   logic                out_of_range_c;
   logic                req_err_c;
   logic [DATA_W-1:0]   fetch_word_c;
   logic                accept_c;

   // Address decode: a wrapped subtraction shows up as addr < base.
   assign word_off_c     = (req_addr - BASE_ADDR) >> 2;
   assign misalign_c     = (req_addr[1:0] != 2'b00);
   assign out_of_range_c = (req_addr < BASE_ADDR) || (word_off_c >= DEPTH_LIM);
   assign req_err_c      = misalign_c || out_of_range_c;
   assign fetch_word_c   = mem_q[word_off_c[IDX_W-1:0]];
   assign accept_c       = req_valid && req_ready_q;

   // Text-segment storage; deliberately not reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem_q[ld_idx] <= ld_data;
      end
   end

   // Next-state, countdown and response capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               addr_d  = req_addr;
               err_d   = req_err_c;
               instr_d = req_err_c ? '0 : fetch_word_c;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, response and handshake flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         instr_q     <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         instr_q     <= instr_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         req_ready_q <= (state_d == IDLE);
         rsp_valid_q <= (state_d == RESP);
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = instr_q;
   assign rsp_addr  = addr_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: a LATENCY=2 instance for most scenarios and
// a LATENCY=1 instance for the back-to-back sweep, sharing clock, reset,
// request address and load port.
module tb_imem_fetch_responder;

   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int          DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req_addr;
   logic        ld_en;
   logic [7:0]  ld_idx;
   logic [31:0] ld_data;

   logic        req_valid, rsp_ready, req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_instr, rsp_addr;
   logic        req_valid1, rsp_ready1, req_ready1, rsp_valid1, rsp_err1;
   logic [31:0] rsp_instr1, rsp_addr1;

   logic [31:0] mem_m [DEPTH];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
      .rsp_addr(rsp_addr), .rsp_err(rsp_err),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
   );

   imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid1), .req_addr(req_addr), .req_ready(req_ready1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_instr(rsp_instr1),
      .rsp_addr(rsp_addr1), .rsp_err(rsp_err1),
      .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte address -> (error, instruction) using wide arithmetic.
   function automatic void model(input logic [31:0] a, output logic err, output logic [31:0] instr);
      longint unsigned lo = longint'(BASE);
      longint unsigned hi = longint'(BASE) + 4 * DEPTH;
      longint unsigned av = longint'(a);
      err   = (av % 4 != 0) || (av < lo) || (av >= hi);
      instr = err ? 32'h0 : mem_m[int'((av - lo) / 4)];
   endfunction

   task automatic load(input int idx, input logic [31:0] data);
      ld_en = 1'b1; ld_idx = 8'(idx); ld_data = data;
      step();
      ld_en = 1'b0;
      mem_m[idx] = data;
   endtask

   // One fetch on the LATENCY=2 instance with optional same-cycle load,
   // response backpressure and ignored request pulses during the hold.
   task automatic fetch_chk(input logic [31:0] addr, input bit race, input int ridx,
                            input logic [31:0] rdata, input int hold, input bit pulse);
      logic        e_err;
      logic [31:0] e_instr;
      int          n;
      model(addr, e_err, e_instr);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_before: got %b expected 1", req_ready);
      end
      req_valid = 1'b1; req_addr = addr;
      if (race) begin
         ld_en = 1'b1; ld_idx = 8'(ridx); ld_data = rdata;
      end
      step();
      req_valid = 1'b0; ld_en = 1'b0;
      if (race) mem_m[ridx] = rdata;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++; $display("FAIL ready_drop: got %b expected 0", req_ready);
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_checks++;
      if (n != 2) begin
         n_fail++; $display("FAIL latency addr=%h: got %0d edges expected 2", addr, n);
      end
      n_checks++;
      if (rsp_instr !== e_instr || rsp_addr !== addr || rsp_err !== e_err) begin
         n_fail++;
         $display("FAIL rsp addr=%h: got instr=%h addr=%h err=%b expected instr=%h addr=%h err=%b",
                  addr, rsp_instr, rsp_addr, rsp_err, e_instr, addr, e_err);
      end
      for (int h = 0; h < hold; h++) begin
         if (pulse) begin
            req_valid = 1'b1; req_addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         end
         step();
         n_checks++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_instr !== e_instr ||
             rsp_addr !== addr || rsp_err !== e_err) begin
            n_fail++;
            $display("FAIL hold%0d: got v=%b r=%b instr=%h addr=%h err=%b expected v=1 r=0 instr=%h addr=%h err=%b",
                     h, rsp_valid, req_ready, rsp_instr, rsp_addr, rsp_err, e_instr, addr, e_err);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL release: got v=%b r=%b expected v=0 r=1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 1'b0; rsp_ready = 1'b0; req_valid1 = 1'b0; rsp_ready1 = 1'b0;
      req_addr = '0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
      #13;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b instr=%h addr=%h err=%b expected all 0",
                  rsp_valid, rsp_instr, rsp_addr, rsp_err);
      end
      n_checks++;
      if (rsp_valid1 !== 1'b0 || rsp_err1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs1: got v=%b err=%b expected 0", rsp_valid1, rsp_err1);
      end
      step();
      rst_n = 1'b1;
      step();
      n_checks++;
      if (req_ready !== 1'b1 || req_ready1 !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b/%b expected 1/1", req_ready, req_ready1);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < DEPTH; i++) load(i, $urandom);
      load(8, 32'h2008_000A);
      fetch_chk(32'h0040_0020, 1'b0, 0, '0, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      fetch_chk(32'h0040_0020, 1'b0, 0, '0, 5, 1'b1);
   endtask

   task automatic test_errors();
      fetch_chk(32'h0040_0022, 1'b0, 0, '0, 0, 1'b0);
      fetch_chk(32'h003F_FFFC, 1'b0, 0, '0, 0, 1'b0);
      fetch_chk(32'h0040_0400, 1'b0, 0, '0, 1, 1'b0);
      fetch_chk(32'hFFFF_FFFC, 1'b0, 0, '0, 0, 1'b0);
   endtask

   task automatic test_load_race();
      load(3, 32'hAAAA_AAAA);
      fetch_chk(32'h0040_000C, 1'b1, 3, 32'hBBBB_BBBB, 0, 1'b0);
      fetch_chk(32'h0040_000C, 1'b0, 0, '0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; req_addr = 32'h0040_0020;
      step();
      req_valid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got r=%b v=%b addr=%h expected r=1 v=0 addr=0",
                  req_ready, rsp_valid, rsp_addr);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_quiet%0d: got v=%b r=%b expected v=0 r=1", i, rsp_valid, req_ready);
         end
      end
      fetch_chk(32'h0040_0020, 1'b0, 0, '0, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      int          cat, ridx;
      bit          race;
      for (int k = 0; k < 40; k++) begin
         cat  = $urandom_range(0, 5);
         race = 1'b0;
         ridx = 0;
         case (cat)
            1:       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            2:       a = 32'($urandom_range(0, 32'h003F_FFFF));
            3:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1 << 20));
            4:       a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            default: begin
               a    = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
               race = ($urandom_range(0, 2) == 0);
               ridx = ($urandom_range(0, 1) == 0) ? int'((a - BASE) >> 2) : $urandom_range(0, DEPTH - 1);
            end
         endcase
         fetch_chk(a, race, ridx, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic        e_err;
      logic [31:0] e_instr;
      rsp_ready1 = 1'b1;
      for (int k = 0; k < 16; k++) begin
         a = BASE + 32'(4 * k);
         model(a, e_err, e_instr);
         req_addr = a; req_valid1 = 1'b1;
         n_checks++;
         if (req_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", k, req_ready1);
         end
         step();
         n_checks++;
         if (rsp_valid1 !== 1'b1 || req_ready1 !== 1'b0 || rsp_instr1 !== e_instr ||
             rsp_addr1 !== a || rsp_err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_rsp%0d: got v=%b r=%b instr=%h addr=%h err=%b expected v=1 r=0 instr=%h addr=%h err=0",
                     k, rsp_valid1, req_ready1, rsp_instr1, rsp_addr1, rsp_err1, e_instr, a);
         end
         step();
         n_checks++;
         if (rsp_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_gap%0d: got v=%b expected 0", k, rsp_valid1);
         end
      end
      req_valid1 = 1'b0;
      rsp_ready1 = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_errors();
      test_load_race();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
